// File: rtl/serial_compare_ctrl.sv
// Serial WIDTH-bit unsigned comparator built on a single 2-bit cascade slice.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish as soon as a differing pair is seen.

module cmp2_slice (
   input  logic [1:0] i_a,
   input  logic [1:0] i_b,
   input  logic       i_eq,
   input  logic       i_gt,
   output logic       o_eq,
   output logic       o_gt
);
   assign o_eq = i_eq & (i_a == i_b);
   assign o_gt = i_gt | (i_eq & (i_a > i_b));
endmodule

module serial_compare_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq_out,
   output logic             gt_out,
   output logic             lt_out
);
   localparam int N  = WIDTH / 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [IW-1:0]    r_idx;
   logic             r_eq;
   logic             r_gt;
   logic [1:0]       w_pa;
   logic [1:0]       w_pb;
   logic             w_eq_s;
   logic             w_gt_s;
   logic             w_accept;
   logic             w_last;

   assign w_pa = 2'(r_opa >> {r_idx, 1'b0});
   assign w_pb = 2'(r_opb >> {r_idx, 1'b0});

   cmp2_slice u_slice (
      .i_a  (w_pa),
      .i_b  (w_pb),
      .i_eq (r_eq),
      .i_gt (r_gt),
      .o_eq (w_eq_s),
      .o_gt (w_gt_s)
   );

   assign w_accept = start & (r_state != S_RUN);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   // MSB-first evaluation: the first differing pair decides the result
   assign w_last = (r_idx == '0) | ~w_eq_s;
`else
   assign w_last = (r_idx == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa  <= '0;
         r_opb  <= '0;
         r_idx  <= '0;
         r_eq   <= 1'b0;
         r_gt   <= 1'b0;
         eq_out <= 1'b0;
         gt_out <= 1'b0;
         lt_out <= 1'b0;
      end else if (w_accept) begin
         r_opa  <= a;
         r_opb  <= b;
         r_idx  <= IW'(N - 1);
         r_eq   <= 1'b1;
         r_gt   <= 1'b0;
         eq_out <= 1'b0;
         gt_out <= 1'b0;
         lt_out <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_eq <= w_eq_s;
         r_gt <= w_gt_s;
         if (w_last) begin
            eq_out <= w_eq_s;
            gt_out <= w_gt_s;
            lt_out <= ~w_eq_s & ~w_gt_s;
         end else begin
            r_idx <= r_idx - IW'(1);
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (WIDTH=8), both build options.

module tb_serial_compare_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic       eq_out;
   logic       gt_out;
   logic       lt_out;

   int n_chk;
   int n_fail;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   serial_compare_ctrl #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .eq_out (eq_out),
      .gt_out (gt_out),
      .lt_out (lt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // start at edge k, then sample #1 after each following edge until done
   task automatic run_op(input string tag, input logic [7:0] va,
                         input logic [7:0] vb, input int lat,
                         input bit e, input bit g, input bit l);
      int got_lat;
      got_lat = 0;
      @(negedge clk);
      start = 1'b1;
      a = va;
      b = vb;
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_clr"}, {eq_out, gt_out, lt_out}, 0);
      for (int i = 1; i <= 20 && got_lat == 0; i++) begin
         @(posedge clk);
         #1;
         if (done) got_lat = i;
      end
      chk({tag, "_lat"}, got_lat, lat);
      chk({tag, "_res"}, {eq_out, gt_out, lt_out}, {e, g, l});
      @(posedge clk);
      #1;
      chk({tag, "_1done"}, {busy, done}, 0);
      chk({tag, "_hold"}, {eq_out, gt_out, lt_out}, {e, g, l});
   endtask

   initial begin
      int d1;
      int d2;
      int nd;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      #12;
      chk("rst_state", {busy, done, eq_out, gt_out, lt_out}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("eq_a5", 8'hA5, 8'hA5, 4, 1, 0, 0);
      run_op("gt_80", 8'h80, 8'h7F, EE ? 1 : 4, 0, 1, 0);
      run_op("lt_12", 8'h12, 8'h13, 4, 0, 0, 1);
      run_op("lt_34", 8'h34, 8'h38, EE ? 3 : 4, 0, 0, 1);
      run_op("gt_ff", 8'hFF, 8'h00, EE ? 1 : 4, 0, 1, 0);
      run_op("eq_00", 8'h00, 8'h00, 4, 1, 0, 0);

      // start during RUN must be ignored
      @(negedge clk);
      start = 1'b1;
      a = 8'h01;
      b = 8'h02;
      @(posedge clk);
      #1 start = 1'b0;
      d1 = 0;
      nd = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 2) begin
            @(negedge clk);
            start = 1'b1;
            a = 8'hFF;
            b = 8'h00;
         end
         @(posedge clk);
         #1 start = 1'b0;
         if (done) begin
            nd++;
            if (d1 == 0) d1 = i;
            chk("ign_res", {eq_out, gt_out, lt_out}, 3'b001);
         end
      end
      chk("ign_lat", d1, 4);
      chk("ign_ndone", nd, 1);

      // back-to-back with start held high
      @(negedge clk);
      start = 1'b1;
      a = 8'h40;
      b = 8'h30;
      @(posedge clk);
      #1;
      a = 8'h30;
      b = 8'h40;
      d1 = 0;
      d2 = 0;
      for (int i = 1; i <= 14 && d2 == 0; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            chk("b2b_nbusy", busy, 0);
            if (d1 == 0) begin
               d1 = i;
               chk("b2b_gt", {eq_out, gt_out, lt_out}, 3'b010);
            end else begin
               d2 = i;
               start = 1'b0;
               chk("b2b_lt", {eq_out, gt_out, lt_out}, 3'b001);
            end
         end else begin
            chk("b2b_busy", busy, 1);
         end
      end
      chk("b2b_d1", d1, EE ? 1 : 4);
      chk("b2b_d2", d2, EE ? 3 : 9);
      @(posedge clk);
      #1;
      chk("b2b_idle", {busy, done}, 0);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      start = 1'b1;
      a = 8'h01;
      b = 8'h02;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", {busy, done, eq_out, gt_out, lt_out}, 0);
      nd = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      chk("arst_ndone", nd, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 8'h80, 8'h7F, EE ? 1 : 4, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
